// File: rtl/hilo_muldiv_unit_if.sv
// Bus between the EX stage and the HI/LO multiply/divide unit.
// start is a one-cycle request; the unit accepts it only when idle and never back-pressures it except via stall.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output start, funct, src_a, src_b, flush,
    input  busy, done, stall, hi, lo, rd_data
  );

  modport slave (
    input  start, funct, src_a, src_b, flush,
    output busy, done, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit owning the HI/LO pair, one shift-add or
// restoring shift-subtract step per cycle, with MFHI/MFLO read-out and a stall request.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  hilo_muldiv_unit_if.slave    bus,
  output logic [1:0]           fsm_state
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;    // product high half, or partial remainder
  logic [WIDTH-1:0] low;    // product low half / multiplier, or quotient / dividend
  logic [WIDTH-1:0] mcand;  // multiplicand, or divisor
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] low_nx;

  always_comb begin
    mul_sum   = low[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};
    div_shift = {acc, low[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    acc_nx    = acc;
    low_nx    = low;
    case (state)
      MUL: begin
        // Carry out of the add lands in the top bit after the right shift.
        acc_nx = mul_sum[WIDTH:1];
        low_nx = {mul_sum[0], low[WIDTH-1:1]};
      end
      DIV: begin
        if (!div_diff[WIDTH]) begin
          acc_nx = div_diff[WIDTH-1:0];
          low_nx = {low[WIDTH-2:0], 1'b1};
        end else begin
          acc_nx = div_shift[WIDTH-1:0];
          low_nx = {low[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      low   <= '0;
      mcand <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && bus.funct == F_MULTU) begin
            mcand <= bus.src_a;
            low   <= bus.src_b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end else if (bus.start && bus.funct == F_DIVU) begin
            mcand <= bus.src_b;
            low   <= bus.src_a;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= DIV;
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_nx;
            low <= low_nx;
            // The same register layout holds {hi,lo} for both operations.
            if (count == LAST) begin
              hi    <= acc_nx;
              lo    <= low_nx;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.hi      = hi;
  assign bus.lo      = lo;
  assign bus.stall   = busy & bus.start &
                       ((bus.funct == F_MFHI) || (bus.funct == F_MFLO) ||
                        (bus.funct == F_MULTU) || (bus.funct == F_DIVU));
  assign bus.rd_data = (bus.funct == F_MFHI) ? hi :
                       (bus.funct == F_MFLO) ? lo : '0;
  assign fsm_state   = state;

endmodule
